// File: rtl/execute_muldiv_stage_if.sv
// Execute-stage bundle: operands, forwarding/ALU controls and mul/div controls in,
// results and stall/busy status out.
interface execute_muldiv_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]    i_SrcAE;
  logic [DATA_WIDTH-1:0]    i_SrcBE;
  logic [DATA_WIDTH-1:0]    i_ResultW;
  logic [DATA_WIDTH-1:0]    i_ALUOutM;
  logic [DATA_WIDTH-1:0]    i_SignImmE;
  logic [1:0]               i_ForwardAE;
  logic [1:0]               i_ForwardBE;
  logic                     i_ALUSrcE;
  logic [3:0]               i_ALUControlE;
  logic [4:0]               i_ShamtE;
  logic [1:0]               i_RegDstE;
  logic [RF_ADDR_WIDTH-1:0] i_RtE;
  logic [RF_ADDR_WIDTH-1:0] i_RdE;
  logic                     i_ValidE;
  logic [2:0]               i_MDOpE;
  logic [1:0]               i_MFSelE;
  logic [RF_ADDR_WIDTH-1:0] o_WriteRegE;
  logic [DATA_WIDTH-1:0]    o_WriteDataE;
  logic [DATA_WIDTH-1:0]    o_ResultE;
  logic                     o_StallE;
  logic                     o_BusyE;
  logic                     o_DivZeroE;

  modport master (
    output i_SrcAE, i_SrcBE, i_ResultW, i_ALUOutM, i_SignImmE, i_ForwardAE, i_ForwardBE,
           i_ALUSrcE, i_ALUControlE, i_ShamtE, i_RegDstE, i_RtE, i_RdE, i_ValidE,
           i_MDOpE, i_MFSelE,
    input  o_WriteRegE, o_WriteDataE, o_ResultE, o_StallE, o_BusyE, o_DivZeroE
  );

  modport slave (
    input  i_SrcAE, i_SrcBE, i_ResultW, i_ALUOutM, i_SignImmE, i_ForwardAE, i_ForwardBE,
           i_ALUSrcE, i_ALUControlE, i_ShamtE, i_RegDstE, i_RtE, i_RdE, i_ValidE,
           i_MDOpE, i_MFSelE,
    output o_WriteRegE, o_WriteDataE, o_ResultE, o_StallE, o_BusyE, o_DivZeroE
  );
endinterface

// File: rtl/execute_muldiv_stage.sv
// MIPS-style execute stage: forwarding muxes and ALU, plus an iterative radix-2
// multiply/divide unit owning the HI/LO registers.
module execute_muldiv_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input logic                   i_clk,
  input logic                   i_rst,
  execute_muldiv_stage_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     hi_reg_r, lo_reg_r;
  logic [W-1:0]     hi_r, lo_r, opb_r;
  logic             is_div_r, res_neg_r, rem_neg_r, busy_r, div_zero_r;

  logic [W-1:0]     src_a_s, src_b_s, alu_b_s, alu_out_s, mag_a_s, mag_b_s;
  logic [W-1:0]     q_fix_s, r_fix_s;
  logic [2*W-1:0]   mul_full_s;
  logic [W:0]       mul_sum_s, div_diff_s;
  logic             md_op_s, mf_s, stall_s, accept_s, signed_op_s, div_op_s;
  logic             neg_a_s, neg_b_s, div_ge_s;

  // Operand forwarding and ALU
  always_comb begin
    case (bus.i_ForwardAE)
      2'b00:   src_a_s = bus.i_SrcAE;
      2'b01:   src_a_s = bus.i_ResultW;
      2'b10:   src_a_s = bus.i_ALUOutM;
      default: src_a_s = '0;
    endcase
    case (bus.i_ForwardBE)
      2'b00:   src_b_s = bus.i_SrcBE;
      2'b01:   src_b_s = bus.i_ResultW;
      2'b10:   src_b_s = bus.i_ALUOutM;
      default: src_b_s = '0;
    endcase
    if (bus.i_ALUSrcE) begin
      alu_b_s = bus.i_SignImmE;
    end else begin
      alu_b_s = src_b_s;
    end
    case (bus.i_ALUControlE)
      4'b0000: alu_out_s = src_a_s & alu_b_s;
      4'b0001: alu_out_s = src_a_s | alu_b_s;
      4'b0010: alu_out_s = src_a_s + alu_b_s;
      4'b0011: alu_out_s = {{(W-1){1'b0}}, (src_a_s < alu_b_s)};
      4'b0100: alu_out_s = src_a_s ^ alu_b_s;
      4'b0101: alu_out_s = ~(src_a_s | alu_b_s);
      4'b0110: alu_out_s = src_a_s - alu_b_s;
      4'b0111: alu_out_s = {{(W-1){1'b0}}, ($signed(src_a_s) < $signed(alu_b_s))};
      4'b1000: alu_out_s = alu_b_s << bus.i_ShamtE;
      4'b1001: alu_out_s = alu_b_s >> bus.i_ShamtE;
      4'b1010: alu_out_s = W'($signed(alu_b_s) >>> bus.i_ShamtE);
      default: alu_out_s = '0;
    endcase
  end

  // Destination register and result select
  always_comb begin
    case (bus.i_RegDstE)
      2'b00:   bus.o_WriteRegE = bus.i_RtE;
      2'b01:   bus.o_WriteRegE = bus.i_RdE;
      2'b10:   bus.o_WriteRegE = RF_ADDR_WIDTH'(31);
      default: bus.o_WriteRegE = '0;
    endcase
    case (bus.i_MFSelE)
      2'b01:   bus.o_ResultE = hi_reg_r;
      2'b10:   bus.o_ResultE = lo_reg_r;
      default: bus.o_ResultE = alu_out_s;
    endcase
  end

  assign bus.o_WriteDataE = src_b_s;
  assign bus.o_BusyE      = busy_r;
  assign bus.o_DivZeroE   = div_zero_r;
  assign bus.o_StallE     = stall_s;

  // Issue decode, operand magnitudes and per-step datapath
  always_comb begin
    md_op_s     = (bus.i_MDOpE >= 3'd1) && (bus.i_MDOpE <= 3'd6);
    mf_s        = (bus.i_MFSelE == 2'b01) || (bus.i_MFSelE == 2'b10);
    stall_s     = bus.i_ValidE & busy_r & (md_op_s | mf_s);
    accept_s    = bus.i_ValidE & md_op_s & ~stall_s;
    signed_op_s = (bus.i_MDOpE == MD_MULT) || (bus.i_MDOpE == MD_DIV);
    div_op_s    = (bus.i_MDOpE == MD_DIV) || (bus.i_MDOpE == MD_DIVU);
    neg_a_s     = signed_op_s & src_a_s[W-1];
    neg_b_s     = signed_op_s & src_b_s[W-1];
    mag_a_s     = neg_a_s ? -src_a_s : src_a_s;
    mag_b_s     = neg_b_s ? -src_b_s : src_b_s;
    // hi_r is the partial product / partial remainder, lo_r the multiplier / quotient
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(W+1){1'b0}});
    div_diff_s  = {hi_r, lo_r[W-1]} - {1'b0, opb_r};
    div_ge_s    = ~div_diff_s[W];
    mul_full_s  = res_neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    q_fix_s     = res_neg_r ? -lo_r : lo_r;
    r_fix_s     = rem_neg_r ? -hi_r : hi_r;
  end

  // Mul/div sequencer and HI/LO registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      hi_reg_r   <= '0;
      lo_reg_r   <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      opb_r      <= '0;
      is_div_r   <= 1'b0;
      res_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      busy_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      div_zero_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (bus.i_MDOpE)
              MD_MTHI: hi_reg_r <= src_a_s;
              MD_MTLO: lo_reg_r <= src_a_s;
              default: begin
                is_div_r  <= div_op_s;
                res_neg_r <= neg_a_s ^ neg_b_s;
                rem_neg_r <= neg_a_s;
                opb_r     <= mag_b_s;
                cnt_r     <= '0;
                busy_r    <= 1'b1;
                // Divide by zero bypasses iteration; FIX writes hi_r/lo_r verbatim
                if (div_op_s && (src_b_s == '0)) begin
                  hi_r       <= src_a_s;
                  lo_r       <= '1;
                  div_zero_r <= 1'b1;
                  state_r    <= FIX;
                end else begin
                  hi_r    <= '0;
                  lo_r    <= mag_a_s;
                  state_r <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          if (is_div_r) begin
            hi_r <= div_ge_s ? div_diff_s[W-1:0] : {hi_r[W-2:0], lo_r[W-1]};
            lo_r <= {lo_r[W-2:0], div_ge_s};
          end else begin
            hi_r <= mul_sum_s[W:1];
            lo_r <= {mul_sum_s[0], lo_r[W-1:1]};
          end
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(W - 1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (div_zero_r) begin
            hi_reg_r <= hi_r;
            lo_reg_r <= lo_r;
          end else if (is_div_r) begin
            hi_reg_r <= r_fix_s;
            lo_reg_r <= q_fix_s;
          end else begin
            hi_reg_r <= mul_full_s[2*W-1:W];
            lo_reg_r <= mul_full_s[W-1:0];
          end
          cnt_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Randomized self-checking bench for execute_muldiv_stage against a 64-bit
// arithmetic reference model of HI/LO.
module tb_execute_muldiv_stage;
  localparam int W = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi, model_lo;

  execute_muldiv_stage_if #(.DATA_WIDTH(W), .RF_ADDR_WIDTH(5)) bus ();
  execute_muldiv_stage #(.DATA_WIDTH(W), .RF_ADDR_WIDTH(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    int          sa, sb;
    longint      p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd3: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'd0; lo = a; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      3'd4: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic set_idle();
    bus.i_SrcAE = '0; bus.i_SrcBE = '0; bus.i_ResultW = '0; bus.i_ALUOutM = '0;
    bus.i_SignImmE = '0; bus.i_ForwardAE = 2'b00; bus.i_ForwardBE = 2'b00;
    bus.i_ALUSrcE = 1'b0; bus.i_ALUControlE = 4'b0010; bus.i_ShamtE = 5'd0;
    bus.i_RegDstE = 2'b00; bus.i_RtE = 5'd0; bus.i_RdE = 5'd0;
    bus.i_ValidE = 1'b0; bus.i_MDOpE = 3'd0; bus.i_MFSelE = 2'b00;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.i_ValidE = 1'b1; bus.i_MDOpE = 3'd0;
    bus.i_MFSelE = 2'b01; #1 hi = bus.o_ResultE;
    bus.i_MFSelE = 2'b10; #1 lo = bus.o_ResultE;
    bus.i_ValidE = 1'b0; bus.i_MFSelE = 2'b00;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo, ghi, glo;
    int busy_cnt, dz_cnt, exp_dz;
    model_md(op, a, b, ehi, elo);
    exp_dz = ((op == 3'd3 || op == 3'd4) && b == 32'd0) ? 1 : 0;
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_MDOpE = op; bus.i_SrcAE = a; bus.i_SrcBE = b;
    @(negedge i_clk);
    bus.i_ValidE = 1'b0; bus.i_MDOpE = 3'd0;
    busy_cnt = 0;
    dz_cnt = 0;
    while (bus.o_BusyE && busy_cnt < 200) begin
      busy_cnt++;
      if (bus.o_DivZeroE) dz_cnt++;
      @(negedge i_clk);
    end
    if (bus.o_DivZeroE) dz_cnt++;
    check_val({tag, "_busy"}, 64'(busy_cnt), exp_dz != 0 ? 64'd1 : 64'(W + 1));
    check_val({tag, "_divzero"}, 64'(dz_cnt), 64'(exp_dz));
    read_hilo(ghi, glo);
    check_val({tag, "_hi"}, {32'd0, ghi}, {32'd0, ehi});
    check_val({tag, "_lo"}, {32'd0, glo}, {32'd0, elo});
    model_hi = ehi;
    model_lo = elo;
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] ghi, glo;
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_MDOpE = op; bus.i_SrcAE = a;
    bus.i_MFSelE = (op == 3'd5) ? 2'b01 : 2'b10;
    #1 check_val({tag, "_oldval"}, {32'd0, bus.o_ResultE}, {32'd0, (op == 3'd5) ? model_hi : model_lo});
    @(negedge i_clk);
    bus.i_ValidE = 1'b0; bus.i_MDOpE = 3'd0; bus.i_MFSelE = 2'b00;
    check_val({tag, "_busy"}, {63'd0, bus.o_BusyE}, 64'd0);
    if (op == 3'd5) model_hi = a; else model_lo = a;
    read_hilo(ghi, glo);
    check_val({tag, "_hi"}, {32'd0, ghi}, {32'd0, model_hi});
    check_val({tag, "_lo"}, {32'd0, glo}, {32'd0, model_lo});
  endtask

  initial begin
    logic [31:0] ghi, glo, ehi, elo, a, b;
    logic [2:0]  op;
    int          stall_cnt;

    set_idle();
    i_rst = 1'b1;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge i_clk);
    check_val("rst_busy", {63'd0, bus.o_BusyE}, 64'd0);
    check_val("rst_divzero", {63'd0, bus.o_DivZeroE}, 64'd0);
    read_hilo(ghi, glo);
    check_val("rst_hilo", {ghi, glo}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_md("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    run_md("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divu_zero", 3'd4, 32'h0000_0005, 32'h0000_0000);
    run_mt("mthi", 3'd5, 32'hDEAD_BEEF);
    run_mt("mtlo", 3'd6, 32'h1234_5678);

    // MFLO three cycles after MULT stalls until FIX exits; ADD in between flows through
    model_md(3'd1, 32'h0000_1234, 32'hFFFF_FF00, ehi, elo);
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_MDOpE = 3'd1; bus.i_SrcAE = 32'h0000_1234; bus.i_SrcBE = 32'hFFFF_FF00;
    @(negedge i_clk);
    bus.i_MDOpE = 3'd0; bus.i_MFSelE = 2'b00; bus.i_ALUControlE = 4'b0010;
    bus.i_SrcAE = 32'd100; bus.i_SrcBE = 32'd23;
    #1 check_val("add_busy_stall", {63'd0, bus.o_StallE}, 64'd0);
    check_val("add_busy_result", {32'd0, bus.o_ResultE}, 64'd123);
    @(negedge i_clk);
    bus.i_ValidE = 1'b0;
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_MFSelE = 2'b10;
    #1 stall_cnt = 0;
    while (bus.o_StallE && stall_cnt < 200) begin
      stall_cnt++;
      @(negedge i_clk);
      #1;
    end
    check_val("mflo_stall_cycles", 64'(stall_cnt), 64'(W - 1));
    check_val("mflo_result", {32'd0, bus.o_ResultE}, {32'd0, elo});
    model_hi = ehi;
    model_lo = elo;
    set_idle();

    // Reset mid-RUN clears state without a clock edge
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_MDOpE = 3'd2; bus.i_SrcAE = 32'd7; bus.i_SrcBE = 32'd9;
    @(negedge i_clk);
    bus.i_ValidE = 1'b0; bus.i_MDOpE = 3'd0;
    repeat (5) @(negedge i_clk);
    check_val("midrun_busy", {63'd0, bus.o_BusyE}, 64'd1);
    #1 i_rst = 1'b1;
    #1 check_val("midrun_rst_busy", {63'd0, bus.o_BusyE}, 64'd0);
    read_hilo(ghi, glo);
    check_val("midrun_rst_hilo", {ghi, glo}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge i_clk);
    i_rst = 1'b0;

    // Forwarding paths, immediate select and destination register
    @(negedge i_clk);
    bus.i_ValidE = 1'b1; bus.i_ForwardAE = 2'b10; bus.i_ALUOutM = 32'hCAFE_0000;
    bus.i_ALUSrcE = 1'b1; bus.i_SignImmE = 32'h0000_00A5; bus.i_ALUControlE = 4'b0010;
    bus.i_ForwardBE = 2'b01; bus.i_ResultW = 32'h0BAD_F00D; bus.i_RegDstE = 2'b10;
    #1 check_val("fwd_aluoutm", {32'd0, bus.o_ResultE}, 64'hCAFE_00A5);
    check_val("fwd_writedata", {32'd0, bus.o_WriteDataE}, 64'h0BAD_F00D);
    check_val("regdst_31", {59'd0, bus.o_WriteRegE}, 64'd31);
    bus.i_ForwardAE = 2'b11;
    #1 check_val("fwd_zero", {32'd0, bus.o_ResultE}, 64'h0000_00A5);
    set_idle();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a = pick();
      b = pick();
      if (op == 3'd5 || op == 3'd6) run_mt($sformatf("rnd%0d", i), op, a);
      else run_md($sformatf("rnd%0d", i), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
